// File: rtl/dtc_pkg.sv
// Shared types and constants for the decision-tree classifier feature loader.
// Optional feature macro: DTC_FEATURE_PARITY_EN (appends an even-parity bit to every frame).
package dtc_pkg;

    // Loader frame-assembly states.
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FULL    = 2'd1,
        DROP    = 2'd2
    } state_e;

    // Default classifier input width.
    localparam int N_FEAT_DEF = 10;

    // Number of serial bits in one well-formed frame.
    function automatic int frame_len(input int n_feat);
`ifdef DTC_FEATURE_PARITY_EN
        return n_feat + 1;
`else
        return n_feat;
`endif
    endfunction

endpackage

// File: rtl/dtc_sat_counter.sv
// Saturating event counter: counts up on inc_i and holds at all-ones, never wraps.
module dtc_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: increment unless already at the saturation value.
    always_comb begin
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dtc_feature_loader.sv
// Feature loader: assembles an LSB-first serial bit stream into an N_FEAT-bit feature
// vector for the classifier. One frame assembles in the shift register while a finished
// frame waits in the output buffer. Malformed frames are dropped and counted.
// Optional feature macro: DTC_FEATURE_PARITY_EN (frame carries a trailing even-parity bit).
module dtc_feature_loader
    import dtc_pkg::*;
#(
    parameter int N_FEAT = N_FEAT_DEF,
    parameter int CNT_W  = 4,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_bit,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [N_FEAT-1:0] m_feat,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int               LEN      = frame_len(N_FEAT);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [N_FEAT-1:0]   sh_q, sh_d;
    logic [N_FEAT-1:0]   feat_q, feat_d;
    logic                mv_q, mv_d;
    logic                err_q, err_d;
    logic [N_FEAT-1:0]   frame_s;
    logic                accept_s;
    logic                parity_ok_s;

    // The loader stalls the serial side only while both buffers are occupied.
    assign s_ready  = (state_q != FULL);
    assign accept_s = s_valid && (state_q != FULL);

`ifdef DTC_FEATURE_PARITY_EN
    // Even parity: data bits plus the trailing parity bit must XOR to zero.
    assign parity_ok_s = ~(^{sh_q, s_bit});
`else
    assign parity_ok_s = 1'b1;
`endif

    // Shift register contents with the incoming bit merged at the current index.
    always_comb begin
        frame_s = sh_q;
        for (int i = 0; i < N_FEAT; i++) begin
            if (idx_q == CNT_W'(i)) begin
                frame_s[i] = s_bit;
            end else begin
                frame_s[i] = sh_q[i];
            end
        end
    end

    // Frame FSM, index counter, shift register and output buffer next-state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        feat_d  = feat_q;
        err_d   = 1'b0;
        if (mv_q && m_ready) begin
            mv_d = 1'b0;
        end else begin
            mv_d = mv_q;
        end

        case (state_q)
            COLLECT: begin
                if (accept_s) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = {CNT_W{1'b0}};
                        if (s_last) begin
                            if (parity_ok_s) begin
                                sh_d = frame_s;
                                if (!mv_q || m_ready) begin
                                    feat_d = frame_s;
                                    mv_d   = 1'b1;
                                end else begin
                                    state_d = FULL;
                                end
                            end else begin
                                err_d = 1'b1;
                            end
                        end else begin
                            // Too long: flag once, then swallow the rest of the frame.
                            err_d   = 1'b1;
                            state_d = DROP;
                        end
                    end else if (s_last) begin
                        // Too short.
                        err_d = 1'b1;
                        idx_d = {CNT_W{1'b0}};
                    end else begin
                        sh_d  = frame_s;
                        idx_d = idx_q + CNT_W'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            FULL: begin
                // Output buffer is always valid here, so m_ready completes a handshake.
                if (m_ready) begin
                    feat_d  = sh_q;
                    mv_d    = 1'b1;
                    state_d = COLLECT;
                end else begin
                    state_d = FULL;
                end
            end
            DROP: begin
                if (accept_s && s_last) begin
                    state_d = COLLECT;
                    idx_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = COLLECT;
                idx_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers; reset discards any partial or held frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            idx_q   <= {CNT_W{1'b0}};
            sh_q    <= {N_FEAT{1'b0}};
            feat_q  <= {N_FEAT{1'b0}};
            mv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            feat_q  <= feat_d;
            mv_q    <= mv_d;
            err_q   <= err_d;
        end
    end

    dtc_sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (err_d),
        .cnt_o (err_cnt)
    );

    assign m_valid   = mv_q;
    assign m_feat    = feat_q;
    assign err_pulse = err_q;

endmodule
